// File: rtl/calc_pkg.sv
// calc_pkg
//   Shared types and constants for the calculator control slice.
//   cmd_t       : 4-bit keypad command codes (digits 0-9, operators, '=', clear)
//   alu_op_t    : operation code driven to the arithmetic unit
//   seq_state_t : states of the operation sequencer FSM
//   DIGIT_MAX   : highest command code that is a decimal digit
//   cmd_to_op() : maps an operator command onto the ALU operation code
package calc_pkg;

  typedef enum logic [3:0] {
    CMD_D0  = 4'h0,
    CMD_D1  = 4'h1,
    CMD_D2  = 4'h2,
    CMD_D3  = 4'h3,
    CMD_D4  = 4'h4,
    CMD_D5  = 4'h5,
    CMD_D6  = 4'h6,
    CMD_D7  = 4'h7,
    CMD_D8  = 4'h8,
    CMD_D9  = 4'h9,
    CMD_ADD = 4'hA,
    CMD_SUB = 4'hB,
    CMD_MUL = 4'hC,
    CMD_DIV = 4'hD,
    CMD_EQ  = 4'hE,
    CMD_CLR = 4'hF
  } cmd_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } alu_op_t;

  typedef enum logic [2:0] {
    S_A,
    S_OP,
    S_B,
    S_WAIT,
    S_RES,
    S_ERR
  } seq_state_t;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  // Operator commands are only ever passed in after being classified as
  // operators, so anything unexpected simply falls back to add.
  function automatic alu_op_t cmd_to_op(input cmd_t c);
    case (c)
      CMD_SUB: return OP_SUB;
      CMD_MUL: return OP_MUL;
      CMD_DIV: return OP_DIV;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/calc_digit_accum.sv
// calc_digit_accum
//   Builds a non-negative decimal operand one digit at a time.
//   clock, reset : system clock, asynchronous active-high reset
//   clear        : value and digit count back to zero
//   load         : start a new operand with the given digit (count = 1)
//   append       : value = value*10 + digit, ignored once MAX_DIGITS are held
//   digit        : decimal digit 0-9
//   value        : current operand
//   value_next   : value as it will be after this edge (lets the caller
//                  register a display copy on the same edge)
module calc_digit_accum #(
  parameter int DATA_W     = 28,
  parameter int MAX_DIGITS = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              append,
  input  logic [3:0]        digit,
  output logic [DATA_W-1:0] value,
  output logic [DATA_W-1:0] value_next
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int WW = DATA_W + 4;

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  // Next operand value. The multiply is done four bits wider than the
  // operand; with at most MAX_DIGITS digits the top bits are always zero, so
  // narrowing back to DATA_W never loses anything.
  always_comb begin
    value_next = value;
    count_next = count;
    if (clear) begin
      value_next = '0;
      count_next = '0;
    end else if (load) begin
      value_next = DATA_W'(digit);
      count_next = CW'(1);
    end else if (append && (count < CW'(MAX_DIGITS))) begin
      value_next = DATA_W'(({4'b0000, value} * WW'(10)) + WW'(digit));
      count_next = count + CW'(1);
    end
  end

  // Operand and digit count registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value <= '0;
      count <= '0;
    end else begin
      value <= value_next;
      count <= count_next;
    end
  end

endmodule

// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer
//   Control FSM between the keypad command stream and the arithmetic unit.
//   clock, reset          : system clock, asynchronous active-high reset
//   cmd_valid/cmd/cmd_ready : keypad command handshake (digit, + - * /, =, clear)
//   alu_req/alu_op/alu_a/alu_b : operation request, held until alu_ack
//   alu_ack/alu_result/alu_err : one-cycle completion from the arithmetic unit
//   disp_value/disp_err   : signed value and error flag for the display
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int DATA_W      = 28,
  parameter int MAX_DIGITS  = 8,
  parameter int ALU_TIMEOUT = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cmd_valid,
  input  logic [3:0]               cmd,
  output logic                     cmd_ready,
  output logic                     alu_req,
  output logic [1:0]               alu_op,
  output logic signed [DATA_W-1:0] alu_a,
  output logic signed [DATA_W-1:0] alu_b,
  input  logic                     alu_ack,
  input  logic signed [DATA_W-1:0] alu_result,
  input  logic                     alu_err,
  output logic signed [DATA_W-1:0] disp_value,
  output logic                     disp_err
);

  localparam int TW = $clog2(ALU_TIMEOUT + 1);

  seq_state_t              state, state_next;
  alu_op_t                 op_reg;
  logic                    wait_eq;
  logic signed [DATA_W-1:0] a_reg;
  logic [TW-1:0]           timer;
  cmd_t                    cmd_e;

  logic accept, is_digit, is_op, is_eq, is_clr;
  logic acc_clear, acc_load, acc_append;
  logic issue, issue_eq, latch_a, latch_op, take_result, go_err, do_clear, show_acc;
  logic [DATA_W-1:0] acc_value, acc_value_next;

  // The operand being typed (A while in S_A, B while in S_OP/S_B) lives in
  // the accumulator; A is copied into a_reg once an operator is entered.
  calc_digit_accum #(
    .DATA_W    (DATA_W),
    .MAX_DIGITS(MAX_DIGITS)
  ) u_accum (
    .clock     (clock),
    .reset     (reset),
    .clear     (acc_clear),
    .load      (acc_load),
    .append    (acc_append),
    .digit     (cmd),
    .value     (acc_value),
    .value_next(acc_value_next)
  );

  assign cmd_ready = (state != S_WAIT);
  assign alu_req   = (state == S_WAIT);
  assign cmd_e     = cmd_t'(cmd);
  assign accept    = cmd_valid && cmd_ready;
  assign is_digit  = (cmd <= DIGIT_MAX);
  assign is_op     = (cmd_e == CMD_ADD) || (cmd_e == CMD_SUB) ||
                     (cmd_e == CMD_MUL) || (cmd_e == CMD_DIV);
  assign is_eq     = (cmd_e == CMD_EQ);
  assign is_clr    = (cmd_e == CMD_CLR);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_A;
    else       state <= state_next;
  end

  // Next state and the per-cycle datapath strobes. Clear wins over
  // everything whenever a command can be accepted; S_WAIT never accepts.
  always_comb begin
    state_next  = state;
    acc_clear   = 1'b0;
    acc_load    = 1'b0;
    acc_append  = 1'b0;
    issue       = 1'b0;
    issue_eq    = 1'b0;
    latch_a     = 1'b0;
    latch_op    = 1'b0;
    take_result = 1'b0;
    go_err      = 1'b0;
    do_clear    = 1'b0;
    show_acc    = 1'b0;
    if (accept && is_clr) begin
      do_clear   = 1'b1;
      acc_clear  = 1'b1;
      state_next = S_A;
    end else begin
      unique case (state)
        S_A: if (accept) begin
          if (is_digit) begin
            acc_append = 1'b1;
            show_acc   = 1'b1;
          end else if (is_op) begin
            latch_a    = 1'b1;
            latch_op   = 1'b1;
            state_next = S_OP;
          end
        end
        S_OP: if (accept) begin
          if (is_digit) begin
            acc_load   = 1'b1;
            show_acc   = 1'b1;
            state_next = S_B;
          end else if (is_op) begin
            latch_op = 1'b1;
          end
        end
        S_B: if (accept) begin
          if (is_digit) begin
            acc_append = 1'b1;
            show_acc   = 1'b1;
          end else if (is_op) begin
            issue      = 1'b1;
            latch_op   = 1'b1;
            state_next = S_WAIT;
          end else if (is_eq) begin
            issue      = 1'b1;
            issue_eq   = 1'b1;
            state_next = S_WAIT;
          end
        end
        S_WAIT: begin
          if (alu_ack) begin
            if (alu_err) begin
              go_err     = 1'b1;
              state_next = S_ERR;
            end else begin
              take_result = 1'b1;
              acc_clear   = 1'b1;
              state_next  = wait_eq ? S_RES : S_OP;
            end
          end else if (timer == TW'(ALU_TIMEOUT - 1)) begin
            go_err     = 1'b1;
            state_next = S_ERR;
          end
        end
        S_RES: if (accept) begin
          if (is_digit) begin
            acc_load   = 1'b1;
            show_acc   = 1'b1;
            state_next = S_A;
          end else if (is_op) begin
            latch_op   = 1'b1;
            state_next = S_OP;
          end
        end
        S_ERR: state_next = S_ERR;
        default: state_next = S_A;
      endcase
    end
  end

  // Operand, operator, request and display registers. On a chained operator
  // the request carries the old pending op while op_reg takes the new one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_reg      <= '0;
      op_reg     <= OP_ADD;
      wait_eq    <= 1'b0;
      timer      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= 2'b00;
      disp_value <= '0;
      disp_err   <= 1'b0;
    end else if (do_clear) begin
      a_reg      <= '0;
      op_reg     <= OP_ADD;
      wait_eq    <= 1'b0;
      timer      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= 2'b00;
      disp_value <= '0;
      disp_err   <= 1'b0;
    end else begin
      if (latch_a)  a_reg  <= $signed(acc_value);
      if (latch_op) op_reg <= cmd_to_op(cmd_e);
      if (issue) begin
        alu_a   <= a_reg;
        alu_b   <= $signed(acc_value);
        alu_op  <= op_reg;
        wait_eq <= issue_eq;
        timer   <= '0;
      end else if (state == S_WAIT) begin
        timer <= timer + TW'(1);
      end
      if (take_result) begin
        a_reg      <= alu_result;
        disp_value <= alu_result;
      end
      if (show_acc) disp_value <= $signed(acc_value_next);
      if (go_err)   disp_err   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb_calc_op_sequencer
//   Self-checking bench for calc_op_sequencer. Each expected ALU request is
//   queued when the command that triggers it is driven; a small ALU model
//   pops it when alu_req rises, compares op/a/b and answers after a chosen
//   delay (or never, for the timeout cases).
module tb_calc_op_sequencer;
  import calc_pkg::*;

  localparam int DATA_W      = 28;
  localparam int ALU_TIMEOUT = 64;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     cmd_valid;
  logic [3:0]               cmd;
  logic                     cmd_ready;
  logic                     alu_req;
  logic [1:0]               alu_op;
  logic signed [DATA_W-1:0] alu_a;
  logic signed [DATA_W-1:0] alu_b;
  logic                     alu_ack;
  logic signed [DATA_W-1:0] alu_result;
  logic                     alu_err;
  logic signed [DATA_W-1:0] disp_value;
  logic                     disp_err;

  typedef struct {
    logic [1:0] op;
    int         a;
    int         b;
    int         delay;
    bit         err;
    bit         noack;
  } req_t;

  req_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  calc_op_sequencer #(
    .DATA_W     (DATA_W),
    .MAX_DIGITS (8),
    .ALU_TIMEOUT(ALU_TIMEOUT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_ready (cmd_ready),
    .alu_req   (alu_req),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ack   (alu_ack),
    .alu_result(alu_result),
    .alu_err   (alu_err),
    .disp_value(disp_value),
    .disp_err  (disp_err)
  );

  always #5 clock = ~clock;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Reference arithmetic for the ALU model and expected display values.
  function automatic int calc(input logic [1:0] op, input int a, input int b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a * b;
      default: return (b == 0) ? 0 : a / b;
    endcase
  endfunction

  task automatic pushReq(input logic [1:0] op, input int a, input int b,
                         input int delay, input bit err, input bit noack);
    req_t e;
    e.op = op; e.a = a; e.b = b; e.delay = delay; e.err = err; e.noack = noack;
    exp_q.push_back(e);
  endtask

  // Waits (bounded) for cmd_ready, then presents one command for one cycle.
  // Called and returns on a falling edge.
  task automatic applyStimulus(input logic [3:0] c);
    int n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!cmd_ready) checkOutput("ready_before_cmd", 32'(cmd_ready), 1);
    cmd       = c;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  // Presents a command for one cycle without waiting for cmd_ready.
  task automatic forceCmd(input logic [3:0] c);
    cmd       = c;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic waitReady(input string tag);
    int n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    checkOutput(tag, 32'(cmd_ready), 1);
  endtask

  task automatic checkIdle(input string pfx);
    checkOutput({pfx, "_ready"},  32'(cmd_ready),  1);
    checkOutput({pfx, "_req"},    32'(alu_req),    0);
    checkOutput({pfx, "_op"},     32'(alu_op),     0);
    checkOutput({pfx, "_a"},      32'(alu_a),      0);
    checkOutput({pfx, "_b"},      32'(alu_b),      0);
    checkOutput({pfx, "_disp"},   32'(disp_value), 0);
    checkOutput({pfx, "_err"},    32'(disp_err),   0);
  endtask

  // ALU model: checks each request against the scoreboard and acks it.
  initial begin : alu_model
    req_t e;
    int   n;
    alu_ack    = 1'b0;
    alu_err    = 1'b0;
    alu_result = '0;
    forever begin
      @(posedge clock);
      #1;
      if (alu_req === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("req_expected", 32'(exp_q.size()), 1);
          e.op = 2'd0; e.a = 0; e.b = 0; e.delay = 1; e.err = 1'b1; e.noack = 1'b0;
        end else begin
          e = exp_q.pop_front();
          checkOutput("alu_op", 32'(alu_op), 32'(e.op));
          checkOutput("alu_a",  32'(alu_a),  e.a);
          checkOutput("alu_b",  32'(alu_b),  e.b);
        end
        if (e.noack) begin
          n = 0;
          while (alu_req === 1'b1 && n < ALU_TIMEOUT * 3) begin
            @(posedge clock);
            #1;
            n++;
          end
          checkOutput("req_release", 32'(alu_req), 0);
        end else begin
          repeat (e.delay - 1) begin
            @(posedge clock);
            #1;
          end
          alu_result = DATA_W'(calc(e.op, e.a, e.b));
          alu_err    = e.err;
          alu_ack    = 1'b1;
          @(posedge clock);
          #1;
          alu_ack = 1'b0;
          alu_err = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd       = 4'd0;
    repeat (3) @(negedge clock);
    checkIdle("rst");
    reset = 1'b0;
    @(negedge clock);
    checkIdle("post_rst");

    // 1 + 1 =
    applyStimulus(4'd1);
    checkOutput("disp_a1", 32'(disp_value), 1);
    applyStimulus(CMD_ADD);
    applyStimulus(4'd1);
    checkOutput("disp_b1", 32'(disp_value), 1);
    pushReq(2'd0, 1, 1, 2, 1'b0, 1'b0);
    applyStimulus(CMD_EQ);
    checkOutput("req_high", 32'(alu_req), 1);
    checkOutput("ready_low", 32'(cmd_ready), 0);
    waitReady("ready_res1");
    checkOutput("disp_res1", 32'(disp_value), calc(2'd0, 1, 1));
    checkOutput("req_low_res1", 32'(alu_req), 0);

    // 3 - 2 = started from a result
    applyStimulus(4'd3);
    checkOutput("disp_new_a", 32'(disp_value), 3);
    applyStimulus(CMD_SUB);
    applyStimulus(4'd2);
    pushReq(2'd1, 3, 2, 1, 1'b0, 1'b0);
    applyStimulus(CMD_EQ);
    waitReady("ready_res2");
    checkOutput("disp_res2", 32'(disp_value), calc(2'd1, 3, 2));

    // 0 - 5 = gives a negative result
    applyStimulus(4'd0);
    applyStimulus(CMD_SUB);
    applyStimulus(4'd5);
    pushReq(2'd1, 0, 5, 3, 1'b0, 1'b0);
    applyStimulus(CMD_EQ);
    waitReady("ready_res3");
    checkOutput("disp_neg", 32'(disp_value), calc(2'd1, 0, 5));

    // 12 + 3 - 5 = with chaining
    applyStimulus(4'd1);
    applyStimulus(4'd2);
    checkOutput("disp_12", 32'(disp_value), 12);
    applyStimulus(CMD_ADD);
    applyStimulus(4'd3);
    pushReq(2'd0, 12, 3, 3, 1'b0, 1'b0);
    applyStimulus(CMD_SUB);
    waitReady("ready_chain");
    checkOutput("disp_chain", 32'(disp_value), calc(2'd0, 12, 3));
    applyStimulus(4'd5);
    pushReq(2'd1, 15, 5, 4, 1'b0, 1'b0);
    applyStimulus(CMD_EQ);
    waitReady("ready_res4");
    checkOutput("disp_res4", 32'(disp_value), 10);

    applyStimulus(CMD_CLR);
    checkIdle("clr1");

    // Nine digits: the ninth is dropped; commands during S_WAIT are ignored
    for (int i = 0; i < 9; i++) applyStimulus(4'd1);
    checkOutput("disp_8dig", 32'(disp_value), 11111111);
    applyStimulus(CMD_ADD);
    applyStimulus(4'd2);
    pushReq(2'd0, 11111111, 2, 5, 1'b0, 1'b0);
    applyStimulus(CMD_EQ);
    forceCmd(4'd7);
    forceCmd(CMD_SUB);
    checkOutput("busy_req", 32'(alu_req), 1);
    checkOutput("busy_a",   32'(alu_a),   11111111);
    checkOutput("busy_b",   32'(alu_b),   2);
    checkOutput("busy_op",  32'(alu_op),  0);
    waitReady("ready_res5");
    checkOutput("disp_res5", 32'(disp_value), calc(2'd0, 11111111, 2));

    // 8 / 0 = reported as an error by the ALU
    applyStimulus(4'd8);
    applyStimulus(CMD_DIV);
    applyStimulus(4'd0);
    pushReq(2'd3, 8, 0, 2, 1'b1, 1'b0);
    applyStimulus(CMD_EQ);
    waitReady("ready_err");
    checkOutput("err_set", 32'(disp_err), 1);
    applyStimulus(4'd5);
    applyStimulus(CMD_ADD);
    applyStimulus(4'd6);
    applyStimulus(CMD_EQ);
    repeat (3) @(negedge clock);
    checkOutput("err_no_req", 32'(alu_req), 0);
    checkOutput("err_hold", 32'(disp_err), 1);
    applyStimulus(CMD_CLR);
    checkIdle("clr2");

    // 4 * 6 = with no ack: timeout
    applyStimulus(4'd4);
    applyStimulus(CMD_MUL);
    applyStimulus(4'd6);
    pushReq(2'd2, 4, 6, 1, 1'b0, 1'b1);
    applyStimulus(CMD_EQ);
    repeat (10) @(negedge clock);
    checkOutput("to_req_held", 32'(alu_req), 1);
    waitReady("ready_to");
    checkOutput("to_err", 32'(disp_err), 1);
    checkOutput("to_req_low", 32'(alu_req), 0);
    applyStimulus(CMD_CLR);
    checkIdle("clr3");

    // Asynchronous reset while a request is outstanding
    applyStimulus(4'd2);
    applyStimulus(CMD_ADD);
    applyStimulus(4'd3);
    pushReq(2'd0, 2, 3, 1, 1'b0, 1'b1);
    applyStimulus(CMD_EQ);
    repeat (2) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_req", 32'(alu_req), 0);
    checkOutput("async_ready", 32'(cmd_ready), 1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkIdle("rst2");

    repeat (5) @(negedge clock);
    checkOutput("queue_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
